muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide unit with HI/LO registers, sitting in the EX stage beside the ALU. It is fed from the ID/EX pipeline register and stalls the pipeline while it works. It executes MULT, MULTU, DIV and DIVU over multiple cycles and MTHI/MTLO in a single cycle. It exposes HI/LO for MFHI/MFLO forwarding into the EX/MEM result path.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is supported.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- valid_i  in  1  request qualifier from the ID/EX register.
- op_i  in  3  operation: 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NONE).
- rs_i  in  WIDTH  operand A / dividend / MTHI-MTLO source.
- rt_i  in  WIDTH  operand B / divisor.
- busy_o  out  1  high while an iterative operation is in flight; the pipeline stalls IF/ID/EX on it.
- done_o  out  1  one-cycle pulse: new HI/LO are visible this cycle.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: busy_o=0.
  - CALC: 32 iterations, 5-bit counter 0..31.
  - FIX: sign correction and HI/LO write.
- IDLE, valid_i=1, op in MULT/MULTU/DIV/DIVU:
  - Latch operand magnitudes; signed ops take the absolute value as 32-bit unsigned.
  - Latch result sign flags.
  - Counter=0, go to CALC.
- IDLE, valid_i=1, op MTHI/MTLO: HI (resp. LO) <= rs_i at that edge; stay IDLE; no busy, no done.
- IDLE, op NONE/reserved, or valid_i=0: no state change.
- CALC, multiply: radix-2 shift-add on a 64-bit product register, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle.
  - 33-bit trial subtract of the divisor from {remainder, next dividend bit}.
  - Keep the result if it is non-negative.
- Counter wraps at 31 -> FIX.
- FIX (multiply): product negated (64-bit two's complement) if signs differ; HI = upper 32 bits, LO = lower 32 bits.
- FIX (divide):
  - LO = quotient, negated if sign(rs)^sign(rt).
  - HI = remainder, negated if sign(rs).
- FIX then returns to IDLE and pulses done_o.
- Divide by zero (rt=0, DIV or DIVU): full latency; HI=rs_i as latched, LO=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap; this falls out of the magnitude arithmetic.
- valid_i while busy_o=1: ignored. The stalled pipeline holds the instruction; it is not re-accepted because the stage advances on done.
- Reset (rst_i=0 at a clock edge), including mid-operation:
  - State IDLE, counter 0, HI=0, LO=0.
  - busy_o=0, done_o=0; internal datapath registers cleared.

## Timing
- Reset values: busy_o=0, done_o=0, hi_o=0, lo_o=0.
- Accept edge E0 (IDLE, valid_i).
- busy_o high from after E0 through the cycle before E33: 33 cycles.
- E1..E32 are the iterations; E33 is the FIX write.
- done_o high for exactly the one cycle after E33.
- hi_o/lo_o change only at the E33 edge (or the MTHI/MTLO edge). They are stable otherwise and never show partial results.
- busy_o and done_o are registered (decoded from state registers); no combinational path from inputs to outputs.
- Back-to-back: a new request is accepted on the edge that ends the done_o cycle, so it may issue while done_o=1.
- MTHI/MTLO latency: 1 edge; visible the next cycle.

## Structure
- Package muldiv_pkg:
  - op_i encodings as named constants.
  - State enum {IDLE, CALC, FIX}.
  - WIDTH default and iteration count (32).
- Single module; no sub-module required. Multiply and divide share the 64-bit working register and the counter.
- The top level wires busy_o into the PC, IFID and IDEX hold enables.
- The top level selects hi_o/lo_o into the EX/MEM ALU-result input for MFHI/MFLO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
  - busy_o high exactly 33 cycles; done_o a single pulse after edge 33.
- MULT rs=0xFFFFFFFD (−3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (−21).
  - MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100/7 -> LO=14, HI=2.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=0x12345678, rt=0 -> HI=0x12345678, LO=0xFFFFFFFF, full 33-cycle busy.
- Start MULT, drive rst_i=0 at cycle 10 -> next cycle busy_o=0, done_o=0, HI=LO=0.
  - A new MULTU issued after reset completes correctly.
- MTHI 0xAAAA5555 then MTLO 0x0000FFFF on consecutive edges -> hi_o/lo_o updated one cycle later, busy_o stays 0.
  - A valid_i pulse with op=MULT during an active DIV is ignored (the DIV result is unchanged).

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings, FSM states and sizing for the multiply/divide unit
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int ITERS     = 32;
  localparam int CNT_W     = $clog2(ITERS);
  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide with HI/LO registers, stalls the pipeline while busy
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH-1:0] opb, q_fix, r_fix;
  logic [WIDTH:0] mul_sum, shifted, diff;
  logic is_div, neg_q, neg_r, dz, done_q;
  logic start, op_div, is_signed, neg_a, neg_b, div_ge;
  assign op_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign start  = valid_i && (op_div || op_i == OP_MULT || op_i == OP_MULTU);
  assign busy_o = state != IDLE;
  assign done_o = done_q;
  // Operand sign handling, one shift-add / restoring-divide step, and final sign correction
  always_comb begin
    is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    neg_a     = is_signed & rs_i[WIDTH-1];
    neg_b     = is_signed & rt_i[WIDTH-1];
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    shifted   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff      = shifted - {1'b0, opb};
    div_ge    = ~diff[WIDTH];
    acc_step  = is_div ? {(div_ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], div_ge}
                       : {mul_sum, acc[WIDTH-1:1]};
    prod_fix  = neg_q ? -acc : acc;
    q_fix     = dz ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    r_fix     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  // Next state: accept in IDLE, iterate until the counter wraps, then one FIX cycle
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (start ? CALC : IDLE)
              : (state == CALC) ? ((cnt == CNT_W'(ITERS - 1)) ? FIX : CALC)
              : IDLE;
  end
  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else state <= state_nxt;
  end
  // Datapath: latch magnitudes on accept, step each CALC cycle, commit HI/LO in FIX
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      done_q <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_q <= state == FIX;
      if (state == IDLE) begin
        if (start) begin
          cnt    <= '0;
          is_div <= op_div;
          neg_q  <= neg_a ^ neg_b;
          neg_r  <= neg_a;
          dz     <= op_div && (rt_i == '0);
          acc    <= {{WIDTH{1'b0}}, (neg_a ? -rs_i : rs_i)};
          opb    <= neg_b ? -rt_i : rt_i;
        end else if (valid_i && op_i == OP_MTHI) begin
          hi_o <= rs_i;
        end else if (valid_i && op_i == OP_MTLO) begin
          lo_o <= rs_i;
        end
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end else begin
        hi_o <= is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_o <= is_div ? q_fix : prod_fix[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard-driven self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b0, valid = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] rs = '0, rt = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int n_cmp = 0, n_err = 0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .rs_i(rs), .rt_i(rt),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sbv = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o == 3'd1) return 64'(sa * sbv);
    if (o == 3'd2) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == 3'd3) begin
      q = sa / sbv;
      r = sa % sbv;
      return {32'(r), 32'(q)};
    end
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    valid = 1'b1;
    op = o;
    rs = a;
    rt = b;
    exp_q.push_back(e);
    @(negedge clk);
    valid = 1'b0;
    op = 3'd0;
  endtask

  task automatic wait_done(output int bc, output bit to);
    bc = 0;
    to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      if (busy) bc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, need 0 0 0 0", busy, done, hi, lo);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu_timing();
    int bc; bit to; logic [63:0] e;
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done(bc, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || {hi, lo} !== e) begin
      n_err++;
      $display("FAIL multu_max: hi=%h lo=%h timeout=%0b, need %h", hi, lo, to, e);
    end
    n_cmp++;
    if (bc != 33) begin
      n_err++;
      $display("FAIL multu_busy_len: busy cycles %0d, need 33", bc);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: done=%b busy=%b after pulse, need 0 0", done, busy);
    end
  endtask

  task automatic test_table();
    logic [2:0]  t_op[6] = '{3'd1, 3'd1, 3'd3, 3'd4, 3'd3, 3'd4};
    logic [31:0] t_a[6]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] t_b[6]  = '{32'd7, 32'h8000_0000, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0};
    logic [63:0] t_e[6]  = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFD,
                             64'h0000_0002_0000_000E, 64'h0000_0000_8000_0000, 64'h1234_5678_FFFF_FFFF};
    int bc; bit to; logic [63:0] e;
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_e[i]);
      wait_done(bc, to);
      e = exp_q.pop_front();
      n_cmp++;
      if (to || bc != 33 || {hi, lo} !== e) begin
        n_err++;
        $display("FAIL table%0d op=%0d: hi=%h lo=%h busy=%0d timeout=%0b, need %h busy=33", i, t_op[i], hi, lo, bc, to, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int bc; bit to; logic [63:0] e;
    logic [2:0] o; logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(1, 4));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      issue(o, a, b, model(o, a, b));
      wait_done(bc, to);
      e = exp_q.pop_front();
      n_cmp++;
      if (to || {hi, lo} !== e) begin
        n_err++;
        $display("FAIL random%0d op=%0d a=%h b=%h: hi=%h lo=%h timeout=%0b, need %h", i, o, a, b, hi, lo, to, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bc; bit to; logic [63:0] e;
    issue(3'd1, 32'd3, 32'd5, 64'd15);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, need 0 0 0 0", busy, done, hi, lo);
    end
    issue(3'd2, 32'h0001_0000, 32'h0003_0000, 64'h0000_0003_0000_0000);
    wait_done(bc, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || {hi, lo} !== e) begin
      n_err++;
      $display("FAIL after_reset_multu: hi=%h lo=%h timeout=%0b, need %h", hi, lo, to, e);
    end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    valid = 1'b1;
    op = 3'd5;
    rs = 32'hAAAA_5555;
    @(negedge clk);
    n_cmp++;
    if (hi !== 32'hAAAA_5555 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mthi: hi=%h busy=%b, need aaaa5555 0", hi, busy);
    end
    op = 3'd6;
    rs = 32'h0000_FFFF;
    @(negedge clk);
    valid = 1'b0;
    op = 3'd0;
    n_cmp++;
    if (lo !== 32'h0000_FFFF || hi !== 32'hAAAA_5555 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, need aaaa5555 0000ffff 0 0", hi, lo, busy, done);
    end
  endtask

  task automatic test_ignore_busy();
    int bc; bit to; logic [63:0] e;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (5) @(negedge clk);
    valid = 1'b1;
    op = 3'd1;
    rs = 32'd9;
    rt = 32'd9;
    @(negedge clk);
    valid = 1'b0;
    op = 3'd0;
    wait_done(bc, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || {hi, lo} !== e) begin
      n_err++;
      $display("FAIL ignore_busy: hi=%h lo=%h timeout=%0b, need %h", hi, lo, to, e);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_busy_idle: busy=%b, need 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit to; logic [63:0] e;
    issue(3'd4, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    wait_done(bc, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || {hi, lo} !== e) begin
      n_err++;
      $display("FAIL b2b_first: hi=%h lo=%h timeout=%0b, need %h", hi, lo, to, e);
    end
    issue(3'd1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b done=%b, need 1 0", busy, done);
    end
    wait_done(bc, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || bc != 33 || {hi, lo} !== e) begin
      n_err++;
      $display("FAIL b2b_second: hi=%h lo=%h busy=%0d timeout=%0b, need %h busy=33", hi, lo, bc, to, e);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_multu_timing();
    test_table();
    test_random();
    test_reset_mid();
    test_mthi_mtlo();
    test_ignore_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
